// File: rtl/cache_victim_wb_buffer_pkg.sv
// Shared definitions for the victim write-back buffer: default geometry,
// derived line/beat sizes and the drain FSM state encoding.
package cache_victim_wb_buffer_pkg;

    localparam int PA_BITS_DEF  = 34;
    localparam int LINELEN_DEF  = 512;
    localparam int BEATLEN_DEF  = 64;
    localparam int DEPTH_DEF    = 2;

    localparam int BEATSPERLINE = LINELEN_DEF / BEATLEN_DEF;
    localparam int LOGBEATS     = $clog2(BEATSPERLINE);
    localparam int OFFSETLEN    = $clog2(LINELEN_DEF / 8);

    typedef enum logic {
        WB_IDLE,
        WB_SEND
    } wbStateT;

endpackage

// File: rtl/cache_victim_wb_buffer_victimentrymatch.sv
// Per-entry line-address comparator: flags a valid victim entry whose line
// tag equals the tag of the miss address being looked up.
module victimentrymatch
    import cache_victim_wb_buffer_pkg::*;
#(
    parameter int TAGW = PA_BITS_DEF - OFFSETLEN
) (
    input  logic            valid,
    input  logic [TAGW-1:0] entryTag,
    input  logic [TAGW-1:0] lookupTag,
    output logic            match
);

    assign match = valid & (entryTag == lookupTag);

endmodule

// File: rtl/cache_victim_wb_buffer.sv
// Victim write-back buffer: a small circular FIFO of evicted dirty lines
// that drains to the bus as fixed-length write bursts, with a combinational
// lookup so a refill of a still-pending victim line can be stalled.
module cache_victim_wb_buffer
    import cache_victim_wb_buffer_pkg::*;
#(
    parameter int PA_BITS = 34,
    parameter int LINELEN = 512,
    parameter int BEATLEN = 64,
    parameter int DEPTH   = 2
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 VictimValid,
    input  logic [PA_BITS-1:0]                   VictimAdr,
    input  logic [LINELEN-1:0]                   VictimLine,
    output logic                                 VictimReady,
    input  logic [PA_BITS-1:0]                   LookupAdr,
    output logic                                 LookupHit,
    output logic                                 BusReq,
    output logic [PA_BITS-1:0]                   BusAdr,
    output logic [BEATLEN-1:0]                   BusWData,
    output logic [$clog2(LINELEN/BEATLEN)-1:0]   BusBeat,
    output logic                                 BusLast,
    input  logic                                 BusAck,
    output logic                                 Empty
);

    localparam int BEATS    = LINELEN / BEATLEN;
    localparam int LOGB     = $clog2(BEATS);
    localparam int OFFL     = $clog2(LINELEN / 8);
    localparam int BYTESLOG = $clog2(BEATLEN / 8);
    localparam int PTRW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNTW     = $clog2(DEPTH) + 1;
    localparam int TAGW     = PA_BITS - OFFL;

    wbStateT           state, stateNext;
    logic [PTRW-1:0]   head, tail;
    logic [CNTW-1:0]   count, countNext;
    logic [LOGB-1:0]   beat;
    logic [DEPTH-1:0]  entryValid;
    logic [DEPTH-1:0]  entryMatch;
    logic [TAGW-1:0]   entryTag  [DEPTH];
    logic [LINELEN-1:0] entryData [DEPTH];
    logic              push, beatAck, lastAck;
    logic              unusedOffsetBits;

    // Pointer advance that wraps at DEPTH even when DEPTH is 1.
    function automatic logic [PTRW-1:0] incPtr(input logic [PTRW-1:0] p);
        if (p == PTRW'(DEPTH - 1)) return '0;
        return p + PTRW'(1);
    endfunction

    // Offset bits of both addresses are irrelevant: lines are always aligned.
    assign unusedOffsetBits = ^{VictimAdr[OFFL-1:0], LookupAdr[OFFL-1:0]};

    // Acceptance is based on current occupancy only; a drain finishing in the
    // same cycle does not free a slot until the next cycle.
    assign VictimReady = (count != CNTW'(DEPTH));
    assign push        = VictimValid & VictimReady;
    assign Empty       = (count == '0);

    assign BusReq   = (state == WB_SEND);
    assign BusBeat  = beat;
    assign BusLast  = BusReq & (beat == LOGB'(BEATS - 1));
    assign BusAdr   = {entryTag[head], OFFL'(0)} + (PA_BITS'(beat) << BYTESLOG);
    assign BusWData = entryData[head][beat*BEATLEN +: BEATLEN];

    assign beatAck   = BusReq & BusAck;
    assign lastAck   = BusLast & BusAck;
    assign countNext = count + CNTW'(push) - CNTW'(lastAck);

    // Drain FSM: start a burst once something is queued, stop when the last
    // beat of the last queued line is accepted.
    always_comb begin
        stateNext = state;
        case (state)
            WB_IDLE: if (count != '0) stateNext = WB_SEND;
            WB_SEND: if (lastAck && (countNext == '0)) stateNext = WB_IDLE;
            default: stateNext = WB_IDLE;
        endcase
    end

    // Control state: FSM, FIFO pointers, occupancy, beat counter, valids.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= WB_IDLE;
            head       <= '0;
            tail       <= '0;
            count      <= '0;
            beat       <= '0;
            entryValid <= '0;
        end else begin
            state <= stateNext;
            count <= countNext;
            if (push) tail <= incPtr(tail);
            if (lastAck) begin
                head <= incPtr(head);
                beat <= '0;
            end else if (beatAck) begin
                beat <= beat + LOGB'(1);
            end
            for (int i = 0; i < DEPTH; i++) begin
                if (lastAck && (head == PTRW'(i))) entryValid[i] <= 1'b0;
                if (push && (tail == PTRW'(i)))    entryValid[i] <= 1'b1;
            end
        end
    end

    // Line storage: written at the tail on push; contents need no reset
    // because the valids gate every use.
    always_ff @(posedge clk) begin
        if (push) begin
            entryTag[tail]  <= VictimAdr[PA_BITS-1:OFFL];
            entryData[tail] <= VictimLine;
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : gMatch
        victimentrymatch #(
            .TAGW(TAGW)
        ) uMatch (
            .valid     (entryValid[g]),
            .entryTag  (entryTag[g]),
            .lookupTag (LookupAdr[PA_BITS-1:OFFL]),
            .match     (entryMatch[g])
        );
    end

    assign LookupHit = |entryMatch;

endmodule

// File: tb/tb_cache_victim_wb_buffer.sv
// Bench for the victim write-back buffer: directed scenarios followed by a
// randomized run compared against a queue-based model of the buffer.
module tb_cache_victim_wb_buffer;

    localparam int PA    = 34;
    localparam int LL    = 512;
    localparam int BL    = 64;
    localparam int DEPTH = 2;
    localparam int BEATS = LL / BL;

    logic          clk;
    logic          reset;
    logic          VictimValid;
    logic [PA-1:0] VictimAdr;
    logic [LL-1:0] VictimLine;
    logic          VictimReady;
    logic [PA-1:0] LookupAdr;
    logic          LookupHit;
    logic          BusReq;
    logic [PA-1:0] BusAdr;
    logic [BL-1:0] BusWData;
    logic [2:0]    BusBeat;
    logic          BusLast;
    logic          BusAck;
    logic          Empty;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [PA-1:0] adr;
        logic [LL-1:0] line;
    } entT;

    cache_victim_wb_buffer #(
        .PA_BITS(PA), .LINELEN(LL), .BEATLEN(BL), .DEPTH(DEPTH)
    ) dut (
        .clk(clk), .reset(reset),
        .VictimValid(VictimValid), .VictimAdr(VictimAdr), .VictimLine(VictimLine),
        .VictimReady(VictimReady),
        .LookupAdr(LookupAdr), .LookupHit(LookupHit),
        .BusReq(BusReq), .BusAdr(BusAdr), .BusWData(BusWData), .BusBeat(BusBeat),
        .BusLast(BusLast), .BusAck(BusAck), .Empty(Empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [LL-1:0] mkLine(input logic [63:0] base);
        logic [LL-1:0] l;
        for (int b = 0; b < BEATS; b++) l[b*BL +: BL] = base + 64'(b);
        return l;
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        VictimValid = 1'b0; VictimAdr = '0; VictimLine = '0;
        BusAck = 1'b0; LookupAdr = '0;
        #12;
        total++;
        if (VictimReady !== 1'b1 || BusReq !== 1'b0 || BusLast !== 1'b0 ||
            LookupHit !== 1'b0 || Empty !== 1'b1) begin
            bad++;
            $display("FAIL reset_state: ready=%b req=%b last=%b hit=%b empty=%b, required 1 0 0 0 1",
                     VictimReady, BusReq, BusLast, LookupHit, Empty);
        end
        @(negedge clk);
        reset = 1'b0;
        step();
        total++;
        if (BusReq !== 1'b0 || Empty !== 1'b1) begin
            bad++;
            $display("FAIL after_reset: req=%b empty=%b, required 0 1", BusReq, Empty);
        end
    endtask

    task automatic test_single_burst();
        logic [PA-1:0] expAdr;
        VictimAdr = 34'h1000; VictimLine = mkLine(64'h0); VictimValid = 1'b1; BusAck = 1'b1;
        #1;
        total++;
        if (VictimReady !== 1'b1) begin
            bad++;
            $display("FAIL single_ready: got %b, required 1", VictimReady);
        end
        step();
        VictimValid = 1'b0;
        total++;
        if (BusReq !== 1'b0) begin
            bad++;
            $display("FAIL single_latency: BusReq=%b right after push, required 0", BusReq);
        end
        step();
        for (int b = 0; b < BEATS; b++) begin
            expAdr = 34'h1000 + 34'(b * 8);
            total++;
            if (BusReq !== 1'b1 || BusAdr !== expAdr || BusWData !== 64'(b) ||
                BusBeat !== 3'(b) || BusLast !== (b == BEATS - 1)) begin
                bad++;
                $display("FAIL single_beat%0d: req=%b adr=%h data=%h beat=%0d last=%b, required 1 %h %h %0d %b",
                         b, BusReq, BusAdr, BusWData, BusBeat, BusLast, expAdr, 64'(b), b, (b == BEATS - 1));
            end
            step();
        end
        total++;
        if (Empty !== 1'b1 || BusReq !== 1'b0) begin
            bad++;
            $display("FAIL single_end: empty=%b req=%b, required 1 0", Empty, BusReq);
        end
    endtask

    task automatic test_full_back_to_back();
        logic [PA-1:0] base;
        BusAck = 1'b0;
        VictimValid = 1'b1; VictimAdr = 34'h2000; VictimLine = mkLine(64'h2000);
        step();
        VictimAdr = 34'h3000; VictimLine = mkLine(64'h3000);
        step();
        VictimAdr = 34'h4000; VictimLine = mkLine(64'h4000);
        #1;
        total++;
        if (VictimReady !== 1'b0 || Empty !== 1'b0) begin
            bad++;
            $display("FAIL full_ready: ready=%b empty=%b, required 0 0", VictimReady, Empty);
        end
        step();
        VictimValid = 1'b0;
        BusAck = 1'b1;
        for (int e = 0; e < 2; e++) begin
            base = (e == 0) ? 34'h2000 : 34'h3000;
            for (int b = 0; b < BEATS; b++) begin
                total++;
                if (BusReq !== 1'b1 || BusAdr !== base + 34'(b * 8) ||
                    BusWData !== 64'(base) + 64'(b) || BusLast !== (b == BEATS - 1)) begin
                    bad++;
                    $display("FAIL b2b_e%0d_beat%0d: req=%b adr=%h data=%h last=%b, required 1 %h %h %b",
                             e, b, BusReq, BusAdr, BusWData, BusLast, base + 34'(b * 8),
                             64'(base) + 64'(b), (b == BEATS - 1));
                end
                if (e == 1 && b == 0) begin
                    total++;
                    if (VictimReady !== 1'b1) begin
                        bad++;
                        $display("FAIL b2b_ready_after_drain: got %b, required 1", VictimReady);
                    end
                end
                step();
            end
        end
        total++;
        if (Empty !== 1'b1 || BusReq !== 1'b0) begin
            bad++;
            $display("FAIL full_third_dropped: empty=%b req=%b, required 1 0", Empty, BusReq);
        end
    endtask

    task automatic test_reject_on_drain();
        BusAck = 1'b0;
        VictimValid = 1'b1; VictimAdr = 34'h6000; VictimLine = mkLine(64'h6000);
        step();
        VictimAdr = 34'h7000; VictimLine = mkLine(64'h7000);
        step();
        VictimValid = 1'b0;
        BusAck = 1'b1;
        repeat (7) step();
        VictimValid = 1'b1; VictimAdr = 34'h8000; VictimLine = mkLine(64'h8000);
        #1;
        total++;
        if (VictimReady !== 1'b0 || BusLast !== 1'b1) begin
            bad++;
            $display("FAIL reject_on_last: ready=%b last=%b, required 0 1", VictimReady, BusLast);
        end
        step();
        total++;
        if (VictimReady !== 1'b1) begin
            bad++;
            $display("FAIL reject_then_ready: got %b, required 1", VictimReady);
        end
        step();
        VictimValid = 1'b0;
        total++;
        if (VictimReady !== 1'b0) begin
            bad++;
            $display("FAIL reassert_accepted: ready=%b, required 0", VictimReady);
        end
        repeat (7) step();
        for (int b = 0; b < BEATS; b++) begin
            total++;
            if (BusReq !== 1'b1 || BusAdr !== 34'h8000 + 34'(b * 8) || BusWData !== 64'h8000 + 64'(b)) begin
                bad++;
                $display("FAIL reassert_beat%0d: req=%b adr=%h data=%h, required 1 %h %h",
                         b, BusReq, BusAdr, BusWData, 34'h8000 + 34'(b * 8), 64'h8000 + 64'(b));
            end
            step();
        end
        total++;
        if (Empty !== 1'b1) begin
            bad++;
            $display("FAIL reject_end_empty: got %b, required 1", Empty);
        end
    endtask

    task automatic test_push_on_last();
        BusAck = 1'b1;
        VictimValid = 1'b1; VictimAdr = 34'h9000; VictimLine = mkLine(64'h9000);
        step();
        VictimValid = 1'b0;
        step();
        repeat (7) step();
        VictimValid = 1'b1; VictimAdr = 34'hA000; VictimLine = mkLine(64'hA000);
        step();
        VictimValid = 1'b0;
        total++;
        if (BusReq !== 1'b1 || BusAdr !== 34'hA000 || BusBeat !== 3'd0 ||
            Empty !== 1'b0 || VictimReady !== 1'b1) begin
            bad++;
            $display("FAIL push_on_last: req=%b adr=%h beat=%0d empty=%b ready=%b, required 1 a000 0 0 1",
                     BusReq, BusAdr, BusBeat, Empty, VictimReady);
        end
        for (int b = 0; b < BEATS; b++) begin
            total++;
            if (BusWData !== 64'hA000 + 64'(b)) begin
                bad++;
                $display("FAIL push_on_last_beat%0d: data=%h, required %h", b, BusWData, 64'hA000 + 64'(b));
            end
            step();
        end
        total++;
        if (Empty !== 1'b1) begin
            bad++;
            $display("FAIL push_on_last_end: empty=%b, required 1", Empty);
        end
    endtask

    task automatic test_lookup();
        BusAck = 1'b0;
        VictimValid = 1'b1; VictimAdr = 34'h2000; VictimLine = mkLine(64'h55);
        LookupAdr = 34'h2000;
        #1;
        total++;
        if (LookupHit !== 1'b0) begin
            bad++;
            $display("FAIL lookup_before_write: hit=%b, required 0", LookupHit);
        end
        step();
        VictimValid = 1'b0;
        LookupAdr = 34'h2010;
        #1;
        total++;
        if (LookupHit !== 1'b1) begin
            bad++;
            $display("FAIL lookup_offset_hit: hit=%b, required 1", LookupHit);
        end
        LookupAdr = 34'h2040;
        #1;
        total++;
        if (LookupHit !== 1'b0) begin
            bad++;
            $display("FAIL lookup_next_line: hit=%b, required 0", LookupHit);
        end
        LookupAdr = 34'h2010;
        BusAck = 1'b1;
        step();
        repeat (7) step();
        total++;
        if (LookupHit !== 1'b1 || BusLast !== 1'b1) begin
            bad++;
            $display("FAIL lookup_while_draining: hit=%b last=%b, required 1 1", LookupHit, BusLast);
        end
        step();
        total++;
        if (LookupHit !== 1'b0 || Empty !== 1'b1) begin
            bad++;
            $display("FAIL lookup_after_drain: hit=%b empty=%b, required 0 1", LookupHit, Empty);
        end
        LookupAdr = '0;
    endtask

    task automatic test_reset_midburst();
        BusAck = 1'b1;
        VictimValid = 1'b1; VictimAdr = 34'hB000; VictimLine = mkLine(64'hB000);
        step();
        VictimValid = 1'b0;
        step();
        repeat (3) step();
        total++;
        if (BusBeat !== 3'd3 || BusReq !== 1'b1) begin
            bad++;
            $display("FAIL midburst_pos: beat=%0d req=%b, required 3 1", BusBeat, BusReq);
        end
        #2 reset = 1'b1;
        #1;
        total++;
        if (BusReq !== 1'b0 || Empty !== 1'b1 || BusLast !== 1'b0 || VictimReady !== 1'b1) begin
            bad++;
            $display("FAIL midburst_reset: req=%b empty=%b last=%b ready=%b, required 0 1 0 1",
                     BusReq, Empty, BusLast, VictimReady);
        end
        @(negedge clk);
        reset = 1'b0;
        VictimValid = 1'b1; VictimAdr = 34'hC000; VictimLine = mkLine(64'hC000);
        step();
        VictimValid = 1'b0;
        step();
        total++;
        if (BusReq !== 1'b1 || BusBeat !== 3'd0 || BusAdr !== 34'hC000 || BusWData !== 64'hC000) begin
            bad++;
            $display("FAIL midburst_restart: req=%b beat=%0d adr=%h data=%h, required 1 0 c000 c000",
                     BusReq, BusBeat, BusAdr, BusWData);
        end
        repeat (BEATS) step();
        total++;
        if (Empty !== 1'b1) begin
            bad++;
            $display("FAIL midburst_end: empty=%b, required 1", Empty);
        end
    endtask

    task automatic test_random();
        entT           q[$];
        entT           e;
        int            beatIdx;
        bit            prevNonEmpty;
        bit            expReq, expHit;
        logic [PA-1:0] expAdr;
        logic [BL-1:0] expData;
        reset = 1'b1;
        VictimValid = 1'b0; BusAck = 1'b0;
        #3;
        @(negedge clk);
        reset = 1'b0;
        beatIdx = 0;
        prevNonEmpty = 1'b0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            VictimValid = ($urandom_range(0, 2) != 0);
            VictimAdr   = 34'h10000 + 34'($urandom_range(0, 7) * 64) + 34'($urandom_range(0, 63));
            for (int k = 0; k < LL / 32; k++) VictimLine[k*32 +: 32] = $urandom();
            BusAck      = ($urandom_range(0, 3) != 0);
            LookupAdr   = 34'h10000 + 34'($urandom_range(0, 7) * 64) + 34'($urandom_range(0, 63));
            #1;
            expReq = prevNonEmpty && (q.size() != 0);
            expHit = 1'b0;
            foreach (q[i]) if (q[i].adr[PA-1:6] == LookupAdr[PA-1:6]) expHit = 1'b1;
            total++;
            if (VictimReady !== (q.size() < DEPTH) || Empty !== (q.size() == 0) ||
                BusReq !== expReq || LookupHit !== expHit) begin
                bad++;
                $display("FAIL rand_ctrl cyc%0d: ready=%b empty=%b req=%b hit=%b, required %b %b %b %b",
                         cyc, VictimReady, Empty, BusReq, LookupHit,
                         (q.size() < DEPTH), (q.size() == 0), expReq, expHit);
            end
            if (expReq) begin
                expAdr  = q[0].adr + 34'(beatIdx * 8);
                expData = q[0].line[beatIdx*BL +: BL];
                total++;
                if (BusAdr !== expAdr || BusWData !== expData || BusBeat !== 3'(beatIdx) ||
                    BusLast !== (beatIdx == BEATS - 1)) begin
                    bad++;
                    $display("FAIL rand_beat cyc%0d: adr=%h data=%h beat=%0d last=%b, required %h %h %0d %b",
                             cyc, BusAdr, BusWData, BusBeat, BusLast, expAdr, expData, beatIdx,
                             (beatIdx == BEATS - 1));
                end
            end
            @(posedge clk);
            prevNonEmpty = (q.size() != 0);
            if (VictimValid && q.size() < DEPTH) begin
                e.adr  = {VictimAdr[PA-1:6], 6'b0};
                e.line = VictimLine;
                if (expReq && BusAck && beatIdx == BEATS - 1) begin
                    void'(q.pop_front());
                    beatIdx = 0;
                end else if (expReq && BusAck) begin
                    beatIdx++;
                end
                q.push_back(e);
            end else if (expReq && BusAck) begin
                if (beatIdx == BEATS - 1) begin
                    void'(q.pop_front());
                    beatIdx = 0;
                end else begin
                    beatIdx++;
                end
            end
            #1;
        end
        VictimValid = 1'b0;
        BusAck = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_burst();
        test_full_back_to_back();
        test_reject_on_drain();
        test_push_on_last();
        test_lookup();
        test_reset_midburst();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
